encoder_8to3_seq: RTL and testbench

ENCODER_8TO3_SEQ -- requirements
Module: encoder_8to3_seq

---
 rtl/encoder_8to3_seq_pkg.sv | 24 ++
 rtl/prio_enc_8to3.sv | 22 ++
 rtl/encoder_8to3_seq.sv | 72 +++++++
 tb/tb_encoder_8to3_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_8to3_seq_pkg.sv
// Shared constants, state encoding and bit helpers for the sequential 8-to-3 encoder.
package encoder_8to3_seq_pkg;

   localparam int W_IN  = 8;
   localparam int W_OUT = 3;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   function automatic logic [W_IN-1:0] idx_mask(input logic [W_OUT-1:0] idx);
      logic [W_IN-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

   // True when exactly one bit of v is set.
   function automatic logic one_hot(input logic [W_IN-1:0] v);
      return (v != '0) && ((v & (v - W_IN'(1))) == '0);
   endfunction

endpackage

// File: rtl/prio_enc_8to3.sv
// Combinational priority encoder: picks the highest or lowest set bit of vec.
module prio_enc_8to3
   import encoder_8to3_seq_pkg::*;
(
   input  logic [W_IN-1:0]  vec,
   input  logic             msb_first,
   output logic [W_OUT-1:0] idx
);

   // Later loop iterations overwrite earlier ones, so scan order sets priority.
   always_comb begin
      idx = '0;
      if (msb_first) begin
         for (int i = 0; i < W_IN; i++)
            if (vec[i]) idx = W_OUT'(i);
      end else begin
         for (int i = W_IN - 1; i >= 0; i--)
            if (vec[i]) idx = W_OUT'(i);
      end
   end

endmodule

// File: rtl/encoder_8to3_seq.sv
// Accepts an 8-bit request vector and streams out the index of each set bit,
// one beat per output handshake, in MSB- or LSB-first order.
module encoder_8to3_seq
   import encoder_8to3_seq_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  d,
   output logic [W_OUT-1:0] o,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             last,
   output logic             none
);

   state_t            state_q, state_d;
   logic [W_IN-1:0]   pending_q, pending_d;
   logic              none_q, none_d;
   logic [W_OUT-1:0]  sel;

   prio_enc_8to3 u_prio (
      .vec       (pending_q),
      .msb_first (MSB_FIRST),
      .idx       (sel)
   );

   // Outputs are pure decode of registered state; pending is zero in IDLE, so o reads 0 there.
   assign o         = sel;
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == EMIT);
   assign last      = out_valid && one_hot(pending_q);
   assign none      = none_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         none_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         none_q    <= none_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      none_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               pending_d = d;
               if (d != '0) state_d = EMIT;
               else         none_d  = 1'b1;
            end
         end
         EMIT: begin
            if (out_ready) begin
               pending_d = pending_q & ~idx_mask(sel);
               if (last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus; a
// reference model fills per-instance beat queues that the monitor drains.
module tb_encoder_8to3_seq;

   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready;
   logic [7:0] d;
   logic [2:0] o1, o0;
   logic       ir1, ir0, ov1, ov0, last1, last0, none1, none0;

   always #5 clk = ~clk;

   encoder_8to3_seq #(.MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .d(d),
      .o(o1), .out_valid(ov1), .out_ready(out_ready), .last(last1), .none(none1));

   encoder_8to3_seq #(.MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .d(d),
      .o(o0), .out_valid(ov0), .out_ready(out_ready), .last(last0), .none(none0));

   typedef struct packed {
      logic [2:0] o;
      logic       last;
   } beat_t;

   typedef struct {
      logic [7:0] d;
      int         nbeats;
      logic [2:0] first_msb;
      logic [2:0] first_lsb;
      int         ready_mode;   // 0 always ready, 1 toggle starting at 1, 2 random
   } vec_t;

   beat_t q1[$], q0[$];
   int    n_checks = 0, n_fail = 0;
   int    beat_cnt;
   logic [2:0] first_o1, first_o0;
   logic  prev_stall = 1'b0;
   logic [2:0] prev_o;
   logic  prev_last;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: expected beats for each ordering.
   task automatic push_model(input logic [7:0] v);
      int rem;
      rem = $countones(v);
      for (int i = 7; i >= 0; i--)
         if (v[i]) begin rem--; q1.push_back('{o: 3'(i), last: (rem == 0)}); end
      rem = $countones(v);
      for (int i = 0; i < 8; i++)
         if (v[i]) begin rem--; q0.push_back('{o: 3'(i), last: (rem == 0)}); end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && ov1) begin
            chk("stall_hold_o", o1, prev_o);
            chk("stall_hold_last", last1, prev_last);
         end
         if (!ov1) chk("last_low_when_idle", last1, 1'b0);
         if (ov1 && out_ready) begin
            beat_t e;
            if (q1.size() == 0) chk("unexpected_beat_msb", 1'b1, 1'b0);
            else begin
               e = q1.pop_front();
               chk("beat_o_msb", o1, e.o);
               chk("beat_last_msb", last1, e.last);
            end
            if (q0.size() == 0) chk("unexpected_beat_lsb", 1'b1, 1'b0);
            else begin
               e = q0.pop_front();
               chk("beat_o_lsb", o0, e.o);
               chk("beat_last_lsb", last0, e.last);
            end
            if (beat_cnt == 0) begin first_o1 = o1; first_o0 = o0; end
            beat_cnt++;
         end
         prev_stall = ov1 && !out_ready;
         prev_o     = o1;
         prev_last  = last1;
      end
   end

   task automatic send(input logic [7:0] v);
      int t;
      push_model(v);
      in_valid = 1'b1;
      d        = v;
      t        = 0;
      while (t < 50) begin
         @(negedge clk);
         if (ir1) break;
         t++;
      end
      if (t >= 50) chk("accept_timeout", 1'b1, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      d        = $urandom_range(0, 255);
   endtask

   task automatic drain(input int mode);
      int t, c;
      t = 0; c = 0;
      while ((q1.size() != 0 || q0.size() != 0) && t < 200) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (c % 2 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         c++; t++;
         @(posedge clk); #1;
      end
      if (t >= 200) chk("drain_timeout", 1'b1, 1'b0);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bubble_in_ready", ir1, 1'b1);
      chk("bubble_out_valid", ov1, 1'b0);
      @(posedge clk); #1;
   endtask

   vec_t tbl[6];

   initial begin
      tbl[0] = '{8'h81, 2, 3'd7, 3'd0, 0};
      tbl[1] = '{8'hFF, 8, 3'd7, 3'd0, 1};
      tbl[2] = '{8'h10, 1, 3'd4, 3'd4, 2};
      tbl[3] = '{8'h5A, 4, 3'd6, 3'd1, 2};
      tbl[4] = '{8'h03, 2, 3'd1, 3'd0, 0};
      tbl[5] = '{8'h80, 1, 3'd7, 3'd7, 1};

      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; d = 8'hA5; beat_cnt = 0;
      repeat (2) @(posedge clk);
      #1; in_valid = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", ir1, 1'b1);
      chk("rst_out_valid", ov1, 1'b0);
      chk("rst_last", last1, 1'b0);
      chk("rst_none", none1, 1'b0);
      chk("rst_o", o1, 3'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", ov1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         out_ready = 1'b0;
         beat_cnt  = 0;
         send(tbl[i].d);
         drain(tbl[i].ready_mode);
         chk("vec_beat_count", 8'(beat_cnt), 8'(tbl[i].nbeats));
         chk("vec_first_msb", first_o1, tbl[i].first_msb);
         chk("vec_first_lsb", first_o0, tbl[i].first_lsb);
      end

      // All-zero vector: single none pulse, no output activity.
      out_ready = 1'b1;
      send(8'h00);
      @(negedge clk);
      chk("zero_none_pulse", none1, 1'b1);
      chk("zero_out_valid", ov1, 1'b0);
      chk("zero_in_ready", ir1, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_none_cleared", none1, 1'b0);
      @(posedge clk); #1;

      // Reset right after the first beat discards the rest of the vector.
      out_ready = 1'b1;
      beat_cnt  = 0;
      send(8'h24);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q1.delete(); q0.delete();
      chk("rst_mid_first_beat", first_o1, 3'd5);
      @(negedge clk);
      chk("rst_mid_out_valid", ov1, 1'b0);
      chk("rst_mid_last", last1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_beats", 8'(beat_cnt), 8'd1);

      // in_valid held during EMIT: second vector only after the bubble.
      beat_cnt = 0;
      push_model(8'h0C);
      push_model(8'h01);
      in_valid = 1'b1; d = 8'h0C; out_ready = 1'b1;
      @(posedge clk); #1;
      d = 8'h01;
      @(negedge clk); chk("hold_in_ready_e1", ir1, 1'b0);
      @(posedge clk); #1;
      @(negedge clk); chk("hold_in_ready_e2", ir1, 1'b0);
      @(posedge clk); #1;
      @(negedge clk); chk("hold_bubble_ready", ir1, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); chk("hold_second_valid", ov1, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("hold_beats", 8'(beat_cnt), 8'd3);
      chk("hold_queue_empty", 8'(q1.size() + q0.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
